// File: rtl/csr_axi_arbiter.sv
// csr_axi_arbiter: round-robin sharing of a single-beat AXI4-lite-style CSR slave port among NREQ clients
module csr_axi_arbiter #(
  parameter int NREQ = 2,
  parameter int ADDR_W = 5,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                   s_aclk,
  input  logic                   s_areset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*32-1:0]     req_wdata,
  input  logic [NREQ*4-1:0]      req_wstrb,
  output logic                   rsp_valid,
  output logic [IW-1:0]          rsp_src,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_W-1:0]      m_axi_awaddr,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [31:0]            m_axi_wdata,
  output logic [3:0]             m_axi_wstrb,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  output logic [ADDR_W-1:0]      m_axi_araddr,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [31:0]            m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
  state_t state;
  logic [IW-1:0] last, src, gnt, hi, lo;
  logic hi_hit;
  logic sel_we;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [31:0] sel_wdata, wdata_q;
  logic [3:0] sel_wstrb, wstrb_q;
  logic aw_done, w_done, aw_fin, w_fin;
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign aw_fin = aw_done | (m_axi_awvalid & m_axi_awready);
  assign w_fin  = w_done | (m_axi_wvalid & m_axi_wready);
  // round-robin pick: lowest requester above last, else wrap to lowest requester overall
  always_comb begin
    hi_hit = 1'b0;
    hi = '0;
    lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IW'(i) > last) begin
          hi_hit = 1'b1;
          hi = IW'(i);
        end else lo = IW'(i);
      end
    end
    gnt = hi_hit ? hi : lo;
  end
  // mux the granted requester's fields
  always_comb begin
    sel_we = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == gnt) begin
        sel_we = req_we[i];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*32 +: 32];
        sel_wstrb = req_wstrb[i*4 +: 4];
      end
    end
  end
  // transaction FSM; the first cycle of each AXI phase raises its valids, handshakes drop them
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      state <= IDLE;
      last <= IW'(NREQ - 1);
      src <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_src <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid <= 1'b0;
      m_axi_bready <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          req_ready <= NREQ'(1) << gnt;
          last <= gnt;
          src <= gnt;
          addr_q <= sel_addr;
          wdata_q <= sel_wdata;
          wstrb_q <= sel_wstrb;
          aw_done <= 1'b0;
          w_done <= 1'b0;
          state <= sel_we ? WR_AW_W : RD_AR;
        end
        WR_AW_W: begin
          m_axi_awvalid <= !aw_fin;
          m_axi_wvalid <= !w_fin;
          aw_done <= aw_fin;
          w_done <= w_fin;
          if (aw_fin && w_fin) begin
            m_axi_bready <= 1'b1;
            state <= WR_B;
          end
        end
        WR_B: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          rsp_err <= |m_axi_bresp;
          rsp_rdata <= '0;
          rsp_src <= src;
          rsp_valid <= 1'b1;
          state <= RSP;
        end
        RD_AR: begin
          m_axi_arvalid <= !(m_axi_arvalid && m_axi_arready);
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_rready <= 1'b1;
            state <= RD_R;
          end
        end
        RD_R: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          rsp_err <= |m_axi_rresp;
          rsp_rdata <= m_axi_rdata;
          rsp_src <= src;
          rsp_valid <= 1'b1;
          state <= RSP;
        end
        RSP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_axi_arbiter.sv
// tb_csr_axi_arbiter: scoreboard bench with a small AXI CSR slave model
module tb_csr_axi_arbiter;
  logic s_aclk = 1'b0;
  logic s_areset;
  logic [1:0] req_valid, req_ready, req_we;
  logic [9:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0] req_wstrb;
  logic rsp_valid, rsp_err;
  logic [0:0] rsp_src;
  logic [31:0] rsp_rdata;
  logic [4:0] m_axi_awaddr, m_axi_araddr;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0] m_axi_wstrb;
  logic [1:0] m_axi_bresp, m_axi_rresp;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

  csr_axi_arbiter #(.NREQ(2), .ADDR_W(5)) dut (
    .s_aclk(s_aclk), .s_areset(s_areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 s_aclk = ~s_aclk;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // slave model: programmable ready delays, held B response, injected read error
  logic [31:0] mem [8];
  logic mem_ok = 1'b0;
  int aw_dly = 0, w_dly = 0, aw_wait, w_wait, aw_hs = 0, w_hs = 0;
  logic b_hold = 1'b0, err_en = 1'b0;
  logic [4:0] err_addr = 5'h1C;
  logic aw_got, w_got, bpend, ag, wg;
  logic [4:0] aw_a, ba;
  logic [31:0] w_d, bd;
  logic [3:0] w_s, bs;
  assign m_axi_awready = m_axi_awvalid && aw_wait >= aw_dly;
  assign m_axi_wready  = m_axi_wvalid && w_wait >= w_dly;
  assign m_axi_bvalid  = bpend && !b_hold;
  assign m_axi_bresp   = 2'b00;
  assign m_axi_arready = m_axi_arvalid;

  always @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0; bpend <= 1'b0;
      m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= '0;
      if (!mem_ok) begin
        for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + i;
        mem_ok <= 1'b1;
      end
    end else begin
      aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
      w_wait <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
      ag = aw_got || (m_axi_awvalid && m_axi_awready);
      wg = w_got || (m_axi_wvalid && m_axi_wready);
      ba = aw_got ? aw_a : m_axi_awaddr;
      bd = w_got ? w_d : m_axi_wdata;
      bs = w_got ? w_s : m_axi_wstrb;
      if (m_axi_awvalid && m_axi_awready) begin aw_hs <= aw_hs + 1; aw_a <= m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin w_hs <= w_hs + 1; w_d <= m_axi_wdata; w_s <= m_axi_wstrb; end
      if (ag && wg) begin
        for (int b = 0; b < 4; b++) if (bs[b]) mem[ba[4:2]][8*b +: 8] = bd[8*b +: 8];
        aw_got <= 1'b0; w_got <= 1'b0; bpend <= 1'b1;
      end else begin
        aw_got <= ag; w_got <= wg;
        if (m_axi_bvalid && m_axi_bready) bpend <= 1'b0;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata <= mem[m_axi_araddr[4:2]];
        m_axi_rresp <= (err_en && m_axi_araddr == err_addr) ? 2'b10 : 2'b00;
      end else if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  // scoreboard queues and monitor
  typedef struct packed {logic [0:0] src; logic [31:0] rdata; logic err;} rsp_t;
  rsp_t rsp_q[$];
  int gnt_q[$];
  rsp_t e;
  int eg, cyc = 0, acc_cyc = 0;
  logic lat_chk = 1'b1;
  logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  logic [4:0] aw_prev, ar_prev;
  logic [35:0] w_prev;

  always @(negedge s_aclk) begin
    if (s_areset) begin
      aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
    end else begin
      cyc++;
      if (|req_ready) begin
        if (gnt_q.size() == 0) chk("unexpected_grant", req_ready, 0);
        else begin
          eg = gnt_q.pop_front();
          chk("grant", req_ready, 2'b01 << eg);
        end
        acc_cyc = cyc;
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = rsp_q.pop_front();
          chk("rsp", {rsp_src, rsp_rdata, rsp_err}, e);
          if (lat_chk) chk("latency", cyc - acc_cyc, 3);
        end
      end
      if (aw_pend) chk("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, aw_prev});
      if (w_pend) chk("w_hold", {m_axi_wvalid, m_axi_wdata, m_axi_wstrb}, {1'b1, w_prev});
      if (ar_pend) chk("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, ar_prev});
      aw_pend = m_axi_awvalid && !m_axi_awready; aw_prev = m_axi_awaddr;
      w_pend = m_axi_wvalid && !m_axi_wready; w_prev = {m_axi_wdata, m_axi_wstrb};
      ar_pend = m_axi_arvalid && !m_axi_arready; ar_prev = m_axi_araddr;
    end
  end

  task automatic wait_ready(input int s);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge s_aclk);
      if (req_ready[s]) break;
    end
    if (n == 300) begin
      checks++; errors++;
      $display("FAIL ready_timeout req%0d actual=none expected=req_ready", s);
    end
  endtask

  task automatic set_req(input int s, input logic we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] st);
    req_we[s] = we;
    req_addr[s*5 +: 5] = a;
    req_wdata[s*32 +: 32] = d;
    req_wstrb[s*4 +: 4] = st;
  endtask

  task automatic issue(input int s, input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err);
    set_req(s, we, a, d, st);
    gnt_q.push_back(s);
    rsp_q.push_back({1'(s), we ? 32'h0 : exp_rd, exp_err});
    req_valid[s] = 1'b1;
    wait_ready(s);
    req_valid[s] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && rsp_q.size() != 0; n++) @(negedge s_aclk);
    repeat (2) @(negedge s_aclk);
    chk("drain", rsp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk({tag, "_data"}, {rsp_rdata, m_axi_wdata}, 0);
    chk({tag, "_misc"}, {m_axi_wstrb, m_axi_awaddr, m_axi_araddr, rsp_src, rsp_err}, 0);
  endtask

  int a0, w0;
  initial begin
    s_areset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge s_aclk);
    chk_zero("reset");
    s_areset = 1'b0;
    @(negedge s_aclk);
    chk_zero("post_reset");
    // contended reads: index 0 first, then strict alternation
    set_req(0, 1'b0, 5'h00, 0, 0);
    set_req(1, 1'b0, 5'h10, 0, 0);
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back(0); rsp_q.push_back({1'b0, 32'hA000_0000, 1'b0});
      gnt_q.push_back(1); rsp_q.push_back({1'b1, 32'hA000_0004, 1'b0});
    end
    req_valid = 2'b11;
    fork
      begin for (int k = 0; k < 4; k++) wait_ready(0); req_valid[0] = 1'b0; end
      begin for (int k = 0; k < 4; k++) wait_ready(1); req_valid[1] = 1'b0; end
    join
    drain();
    // write then read back
    issue(0, 1'b1, 5'h00, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    issue(0, 1'b0, 5'h00, 0, 0, 32'hDEADBEEF, 1'b0);
    drain();
    // AW late, then W late
    lat_chk = 1'b0;
    aw_dly = 3; w_dly = 0; a0 = aw_hs; w0 = w_hs;
    issue(1, 1'b1, 5'h0C, 32'h11112222, 4'hF, 0, 1'b0);
    drain();
    chk("aw_late_aw_hs", aw_hs - a0, 1);
    chk("aw_late_w_hs", w_hs - w0, 1);
    aw_dly = 0; w_dly = 3; a0 = aw_hs; w0 = w_hs;
    issue(0, 1'b1, 5'h0C, 32'h33334444, 4'hF, 0, 1'b0);
    drain();
    chk("w_late_aw_hs", aw_hs - a0, 1);
    chk("w_late_w_hs", w_hs - w0, 1);
    w_dly = 0;
    lat_chk = 1'b1;
    issue(1, 1'b0, 5'h0C, 0, 0, 32'h33334444, 1'b0);
    drain();
    // read error response
    err_en = 1'b1;
    issue(1, 1'b0, 5'h1C, 0, 0, 32'hA000_0007, 1'b1);
    drain();
    err_en = 1'b0;
    // partial strobe merge
    issue(0, 1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    issue(0, 1'b1, 5'h04, 32'h12345678, 4'b0011, 0, 1'b0);
    issue(0, 1'b0, 5'h04, 0, 0, 32'hDEAD5678, 1'b0);
    drain();
    // asynchronous reset while waiting for B
    b_hold = 1'b1;
    issue(0, 1'b1, 5'h08, 32'h55, 4'hF, 0, 1'b0);
    for (int n = 0; n < 50 && !m_axi_bready; n++) @(negedge s_aclk);
    chk("reached_wr_b", m_axi_bready, 1);
    #1 s_areset = 1'b1;
    #1 chk_zero("async_reset");
    rsp_q.delete();
    gnt_q.delete();
    repeat (2) @(negedge s_aclk);
    s_areset = 1'b0;
    b_hold = 1'b0;
    issue(1, 1'b0, 5'h00, 0, 0, 32'hDEADBEEF, 1'b0);
    drain();
    chk("grants_consumed", gnt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
